spgd_dither_seq: RTL and testbench

- Single-channel SPGD controller that sequences the ADC acquisition / DAC output loop.
- Each iteration runs three steps:
  - Applies a random-sign dither (base ± amplitude) to the DAC code and waits a settle time.
  - Triggers one averaged ADC acquisition per dither polarity and captures the calibrated metric.
  - Updates the base DAC code by the scaled metric difference (gradient ascent).
- Sits between the GPIO/config registers and the acquisition block: it drives the acquisition enable, consumes the acquisition done flag and the registered calibrated metric, and drives the DAC code.

---
 rtl/spgd_dither_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_spgd_dither_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spgd_dither_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : spgd_dither_seq                                               |
// | Description : Single-channel SPGD loop sequencer. Applies a random-sign DAC |
// |               dither, runs one ADC acquisition per polarity, and steps the  |
// |               base code along the scaled metric difference.                 |
// |               Optional macro ACQ_TIMEOUT_EN adds a sticky timeout on ACQ_x. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module spgd_dither_seq #(
    parameter int DAC_WIDTH     = 14,
    parameter int METRIC_WIDTH  = 32,
    parameter int SETTLE_WIDTH  = 16,
    parameter int ITER_WIDTH    = 16,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic                           ADC_CLK,
    input  logic                           RST_N,
    input  logic                           START,
    input  logic [DAC_WIDTH-1:0]           INIT_CODE,
    input  logic [DAC_WIDTH-1:0]           DITHER_AMP,
    input  logic [SETTLE_WIDTH-1:0]        SETTLE_CYCLES,
    input  logic [4:0]                     STEP_SHIFT,
    output logic                           ACQ_EN,
    input  logic                           ACQ_DONE,
    input  logic signed [METRIC_WIDTH-1:0] METRIC,
    output logic [DAC_WIDTH-1:0]           DAC_CODE,
    output logic [DAC_WIDTH-1:0]           BASE_CODE,
    output logic [ITER_WIDTH-1:0]          ITER_CNT,
    output logic                           BUSY,
    output logic                           ERR
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_A    = 3'd1,
        ST_SETTLE_A = 3'd2,
        ST_ACQ_A    = 3'd3,
        ST_SET_B    = 3'd4,
        ST_SETTLE_B = 3'd5,
        ST_ACQ_B    = 3'd6,
        ST_UPDATE   = 3'd7
    } state_t;

`ifdef ACQ_TIMEOUT_EN
    localparam bit c_tmo_en = 1'b1;
`else
    localparam bit c_tmo_en = 1'b0;
`endif

    localparam logic [DAC_WIDTH-1:0]            c_code_max  = '1;
    localparam logic [TIMEOUT_WIDTH-1:0]        c_tmo_max   = '1;
    localparam logic [15:0]                     c_lfsr_seed = 16'hACE1;
    localparam logic signed [METRIC_WIDTH+1:0]  c_g_max     =
        $signed({{(METRIC_WIDTH+2-DAC_WIDTH){1'b0}}, c_code_max});
    localparam logic signed [METRIC_WIDTH+1:0]  c_g_min     = -c_g_max;

    state_t                          state_q, state_d;
    logic [DAC_WIDTH-1:0]            dac_q, dac_d;
    logic [DAC_WIDTH-1:0]            base_q, base_d;
    logic [ITER_WIDTH-1:0]           iter_q, iter_d;
    logic [SETTLE_WIDTH-1:0]         settle_q, settle_d;
    logic [TIMEOUT_WIDTH-1:0]        tmo_q, tmo_d;
    logic [15:0]                     lfsr_q, lfsr_d;
    logic signed [METRIC_WIDTH-1:0]  ja_q, ja_d, jb_q, jb_d;
    logic                            acq_en_q, acq_en_d;
    logic                            busy_q, busy_d;
    logic                            err_q, err_d;

    logic                            sign;
    logic [DAC_WIDTH:0]              amp_sum;
    logic [DAC_WIDTH-1:0]            code_up, code_dn, code_a, code_b;
    logic [SETTLE_WIDTH-1:0]         settle_load;
    logic signed [METRIC_WIDTH:0]    diff, diff_sh;
    logic signed [METRIC_WIDTH+1:0]  g_ext, g_raw, g_sat, base_sum;
    logic [DAC_WIDTH-1:0]            base_upd;
    logic                            acq_timeout;

    // Dither codes and gradient step, all from registered state
    always_comb begin
        sign        = lfsr_q[0];
        amp_sum     = {1'b0, base_q} + {1'b0, DITHER_AMP};
        code_up     = amp_sum[DAC_WIDTH] ? c_code_max : amp_sum[DAC_WIDTH-1:0];
        code_dn     = (DITHER_AMP > base_q) ? '0 : (base_q - DITHER_AMP);
        code_a      = sign ? code_up : code_dn;
        code_b      = sign ? code_dn : code_up;
        settle_load = (SETTLE_CYCLES == '0) ? SETTLE_WIDTH'(1) : SETTLE_CYCLES;

        diff    = $signed({ja_q[METRIC_WIDTH-1], ja_q}) - $signed({jb_q[METRIC_WIDTH-1], jb_q});
        diff_sh = diff >>> STEP_SHIFT;
        // Extra bit so negating the most negative shifted difference cannot overflow
        g_ext   = $signed({diff_sh[METRIC_WIDTH], diff_sh});
        g_raw   = sign ? g_ext : -g_ext;
        if (g_raw > c_g_max) begin
            g_sat = c_g_max;
        end else if (g_raw < c_g_min) begin
            g_sat = c_g_min;
        end else begin
            g_sat = g_raw;
        end
        base_sum = $signed({{(METRIC_WIDTH+2-DAC_WIDTH){1'b0}}, base_q}) + g_sat;
        if (base_sum < 0) begin
            base_upd = '0;
        end else if (base_sum > c_g_max) begin
            base_upd = c_code_max;
        end else begin
            base_upd = base_sum[DAC_WIDTH-1:0];
        end

        acq_timeout = c_tmo_en && !ACQ_DONE && (tmo_q == c_tmo_max);
    end

    always_comb begin
        state_d  = state_q;
        dac_d    = dac_q;
        base_d   = base_q;
        iter_d   = iter_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        lfsr_d   = lfsr_q;
        ja_d     = ja_q;
        jb_d     = jb_q;
        acq_en_d = acq_en_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    base_d  = INIT_CODE;
                    state_d = ST_SET_A;
                end
            end
            ST_SET_A, ST_SET_B: begin
                // Hold off until the previous acquisition has released its done flag
                if (!ACQ_DONE) begin
                    dac_d    = (state_q == ST_SET_A) ? code_a : code_b;
                    settle_d = settle_load;
                    state_d  = (state_q == ST_SET_A) ? ST_SETTLE_A : ST_SETTLE_B;
                end
            end
            ST_SETTLE_A, ST_SETTLE_B: begin
                if (settle_q <= SETTLE_WIDTH'(1)) begin
                    acq_en_d = 1'b1;
                    tmo_d    = '0;
                    state_d  = (state_q == ST_SETTLE_A) ? ST_ACQ_A : ST_ACQ_B;
                end else begin
                    settle_d = settle_q - SETTLE_WIDTH'(1);
                end
            end
            ST_ACQ_A, ST_ACQ_B: begin
                if (ACQ_DONE) begin
                    acq_en_d = 1'b0;
                    if (state_q == ST_ACQ_A) begin
                        ja_d    = METRIC;
                        state_d = ST_SET_B;
                    end else begin
                        jb_d    = METRIC;
                        state_d = ST_UPDATE;
                    end
                end else if (acq_timeout) begin
                    acq_en_d = 1'b0;
                    err_d    = 1'b1;
                    dac_d    = base_q;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
                end
            end
            ST_UPDATE: begin
                base_d = base_upd;
                iter_d = iter_q + ITER_WIDTH'(1);
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                if (START) begin
                    state_d = ST_SET_A;
                end else begin
                    dac_d   = base_upd;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ADC_CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            dac_q    <= '0;
            base_q   <= '0;
            iter_q   <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            lfsr_q   <= c_lfsr_seed;
            ja_q     <= '0;
            jb_q     <= '0;
            acq_en_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dac_q    <= dac_d;
            base_q   <= base_d;
            iter_q   <= iter_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            lfsr_q   <= lfsr_d;
            ja_q     <= ja_d;
            jb_q     <= jb_d;
            acq_en_q <= acq_en_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign ACQ_EN    = acq_en_q;
    assign DAC_CODE  = dac_q;
    assign BASE_CODE = base_q;
    assign ITER_CNT  = iter_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spgd_dither_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_spgd_dither_seq                                            |
// | Description : Directed vector bench for spgd_dither_seq (ACQ_TIMEOUT_EN     |
// |               selects the timeout scenario).                                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_spgd_dither_seq;

    localparam int DW = 14;
    localparam int MW = 32;
    localparam int SW = 16;
    localparam int IW = 16;
`ifdef ACQ_TIMEOUT_EN
    localparam int TW = 8;
`else
    localparam int TW = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] init_code;
    logic [DW-1:0] dither_amp;
    logic [SW-1:0] settle_cycles;
    logic [4:0]    step_shift;
    logic          acq_en;
    logic          acq_done;
    logic [MW-1:0] metric;
    logic [DW-1:0] dac_code;
    logic [DW-1:0] base_code;
    logic [IW-1:0] iter_cnt;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spgd_dither_seq #(
        .DAC_WIDTH    (DW),
        .METRIC_WIDTH (MW),
        .SETTLE_WIDTH (SW),
        .ITER_WIDTH   (IW),
        .TIMEOUT_WIDTH(TW)
    ) dut (
        .ADC_CLK      (clk),
        .RST_N        (rst_n),
        .START        (start),
        .INIT_CODE    (init_code),
        .DITHER_AMP   (dither_amp),
        .SETTLE_CYCLES(settle_cycles),
        .STEP_SHIFT   (step_shift),
        .ACQ_EN       (acq_en),
        .ACQ_DONE     (acq_done),
        .METRIC       (metric),
        .DAC_CODE     (dac_code),
        .BASE_CODE    (base_code),
        .ITER_CNT     (iter_cnt),
        .BUSY         (busy),
        .ERR          (err)
    );

    typedef struct {
        bit            rst;
        logic [DW-1:0] init;
        logic [DW-1:0] amp;
        logic [SW-1:0] settle;
        logic [4:0]    shift;
        logic [MW-1:0] ja;
        logic [MW-1:0] jb;
        logic [DW-1:0] code_a;
        logic [DW-1:0] code_b;
        logic [DW-1:0] base;
        logic [IW-1:0] iter;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        acq_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_en(input logic lvl, input string name);
        int k = 0;
        while (acq_en !== lvl && k < 300) begin
            tick();
            k++;
        end
        check(name, acq_en, lvl);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 300) begin
            tick();
            k++;
        end
        check(name, busy, 1'b0);
    endtask

    // Acquisition model: reports done two cycles after enable, then releases
    task automatic respond(input logic [MW-1:0] m, input string name);
        tick();
        tick();
        acq_done = 1'b1;
        metric   = m;
        tick();
        check(name, acq_en, 1'b0);
        acq_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit hold_ok;

        // Signs after reset: s = 1, 0, 0, 0, ...
        vecs[0] = '{1'b1, 14'd8000,  14'd100, 16'd10, 5'd4, 32'h0000_1000, 32'h0000_0000, 14'd8100,  14'd7900,  14'd8256,  16'd1};
        vecs[1] = '{1'b0, 14'd8000,  14'd100, 16'd10, 5'd4, 32'h0000_1000, 32'h0000_0000, 14'd7900,  14'd8100,  14'd7744,  16'd2};
        vecs[2] = '{1'b0, 14'd16300, 14'd200, 16'd3,  5'd2, 32'h0000_0000, 32'h0000_0400, 14'd16100, 14'd16383, 14'd16383, 16'd3};
        vecs[3] = '{1'b0, 14'd50,    14'd200, 16'd0,  5'd0, 32'd5,         32'd7,         14'd0,     14'd250,   14'd52,    16'd4};
        vecs[4] = '{1'b1, 14'd16300, 14'd200, 16'd1,  5'd0, 32'h7FFF_FFFF, 32'h8000_0000, 14'd16383, 14'd16100, 14'd16383, 16'd1};
        vecs[5] = '{1'b1, 14'd50,    14'd200, 16'd2,  5'd0, 32'h8000_0000, 32'h7FFF_FFFF, 14'd250,   14'd0,     14'd0,     16'd1};
        vecs[6] = '{1'b0, 14'd1000,  14'd0,   16'd5,  5'd8, 32'h1234_5678, 32'h0000_0000, 14'd1000,  14'd1000,  14'd0,     16'd2};
        vecs[7] = '{1'b0, 14'd1000,  14'd10,  16'd2,  5'd3, 32'h0000_0000, 32'd100,       14'd990,   14'd1010,  14'd1013,  16'd3};

        rst_n         = 1'b0;
        start         = 1'b0;
        acq_done      = 1'b0;
        metric        = '0;
        init_code     = 14'd8000;
        dither_amp    = 14'd100;
        settle_cycles = 16'd10;
        step_shift    = 5'd4;
        do_reset();
        check("rst_dac", dac_code, 0);
        check("rst_base", base_code, 0);
        check("rst_iter", iter_cnt, 0);
        check("rst_acq_en", acq_en, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        // Reset in the middle of SETTLE_A while START stays high
        start = 1'b1;
        repeat (4) tick();
        check("mid_settle_dac", dac_code, 8100);
        check("mid_settle_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_dac", dac_code, 0);
        check("midrst_acq_en", acq_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_iter", iter_cnt, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        // Settle dwell on both polarities plus SET_B held off by a lingering done
        do_reset();
        start = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (acq_en === 1'b1) break;
            if (dac_code == 14'd8100) cnt++;
        end
        check("dwell_a_en", acq_en, 1);
        check("dwell_a_cycles", cnt, 10);
        start = 1'b0;
        tick();
        acq_done = 1'b1;
        metric   = 32'h0000_1000;
        tick();
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (acq_en !== 1'b0 || dac_code !== 14'd8100) hold_ok = 1'b0;
            tick();
        end
        check("setb_hold", hold_ok, 1);
        acq_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (acq_en === 1'b1) break;
            if (dac_code == 14'd7900) cnt++;
        end
        check("dwell_b_en", acq_en, 1);
        check("dwell_b_cycles", cnt, 10);
        respond(32'h0, "dwell_b_release");
        wait_idle("dwell_idle");
        check("dwell_base", base_code, 8256);
        check("dwell_dac", dac_code, 8256);
        check("dwell_iter", iter_cnt, 1);

        // One iteration per row; START drops during ACQ_A so each ends in IDLE
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst) do_reset();
            init_code     = vecs[i].init;
            dither_amp    = vecs[i].amp;
            settle_cycles = vecs[i].settle;
            step_shift    = vecs[i].shift;
            start         = 1'b1;
            wait_en(1'b1, $sformatf("v%0d_acq_a", i));
            check($sformatf("v%0d_code_a", i), dac_code, vecs[i].code_a);
            check($sformatf("v%0d_busy", i), busy, 1);
            start = 1'b0;
            respond(vecs[i].ja, $sformatf("v%0d_rel_a", i));
            wait_en(1'b1, $sformatf("v%0d_acq_b", i));
            check($sformatf("v%0d_code_b", i), dac_code, vecs[i].code_b);
            respond(vecs[i].jb, $sformatf("v%0d_rel_b", i));
            wait_idle($sformatf("v%0d_idle", i));
            check($sformatf("v%0d_base", i), base_code, vecs[i].base);
            check($sformatf("v%0d_dac", i), dac_code, vecs[i].base);
            check($sformatf("v%0d_iter", i), iter_cnt, vecs[i].iter);
        end

        // Acquisition that never completes
        do_reset();
        init_code     = 14'd4000;
        dither_amp    = 14'd10;
        settle_cycles = 16'd1;
        start         = 1'b1;
        wait_en(1'b1, "tmo_acq_a");
        start = 1'b0;
`ifdef ACQ_TIMEOUT_EN
        cnt = 0;
        while (err !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
        check("tmo_err", err, 1);
        check("tmo_cycles_in_window", (cnt >= 254 && cnt <= 258), 1);
        check("tmo_busy", busy, 0);
        check("tmo_acq_en", acq_en, 0);
        check("tmo_base", base_code, 4000);
        check("tmo_dac", dac_code, 4000);
        tick();
        check("tmo_err_sticky", err, 1);
`else
        repeat (300) tick();
        check("notmo_acq_en", acq_en, 1);
        check("notmo_busy", busy, 1);
        check("notmo_err", err, 0);
`endif
        do_reset();
        check("final_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
